// File: rtl/pio_led_fader.sv
// pio_led_fader: PIO bits to per-channel PWM LED drive with linear fade (clk, reset, pio_in, fade_en -> led_out, frame_pulse)
module pio_led_fader #(
  parameter int N_CH     = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 94,
  parameter int STEP     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pio_in,
  input  logic            fade_en,
  output logic [N_CH-1:0] led_out,
  output logic            frame_pulse
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(STEP);
  logic [PW-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_CH-1:0][PWM_BITS-1:0] duty, duty_nxt;
  logic [N_CH-1:0] led_nxt;
  logic [PWM_BITS-1:0] tgt;
  logic [PWM_BITS:0] up, dn;
  logic tick, frame_end;
  assign tick = presc == P_LAST;
  assign frame_end = tick && pwm_cnt == MAX;
  always_comb begin
    duty_nxt = duty;
    led_nxt = '0;
    tgt = '0;
    up = '0;
    dn = '0;
    for (int c = 0; c < N_CH; c++) begin
      tgt = pio_in[c] ? MAX : '0;
      up = {1'b0, duty[c]} + STEP_W;
      dn = {1'b0, duty[c]} - STEP_W;
      duty_nxt[c] = !fade_en ? tgt
                  : !frame_end ? duty[c]
                  : duty[c] < tgt ? (up > {1'b0, MAX} ? MAX : up[PWM_BITS-1:0])
                  : duty[c] > tgt ? (dn[PWM_BITS] ? '0 : dn[PWM_BITS-1:0])
                  : duty[c];
      led_nxt[c] = duty[c] == MAX || pwm_cnt < duty[c];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      pwm_cnt <= '0;
      duty <= '0;
      led_out <= '0;
      frame_pulse <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      duty <= duty_nxt;
      led_out <= led_nxt;
      frame_pulse <= frame_end;
    end
  end
endmodule

// File: tb/tb_pio_led_fader.sv
// tb_pio_led_fader: randomized and directed checks of fade, snap, timing and reset against a frame-level duty model
module tb_pio_led_fader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] pio [3];
  logic [7:0] led [3];
  logic fade [3];
  logic fp [3];
  int tests = 0;
  int fails = 0;
  int md [3][8];
  int st [3] = '{64, 10, 100};
  int ps [3] = '{1, 3, 1};
  logic [7:0] pats [8] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h80, 8'h01, 8'h01, 8'h00};
  int bad;
  always #5 clk = ~clk;
  pio_led_fader #(.N_CH(8), .PWM_BITS(8), .PRESCALE(1), .STEP(64)) u_a (
    .clk(clk), .reset(reset), .pio_in(pio[0]), .fade_en(fade[0]), .led_out(led[0]), .frame_pulse(fp[0]));
  pio_led_fader #(.N_CH(8), .PWM_BITS(8), .PRESCALE(3), .STEP(10)) u_b (
    .clk(clk), .reset(reset), .pio_in(pio[1]), .fade_en(fade[1]), .led_out(led[1]), .frame_pulse(fp[1]));
  pio_led_fader #(.N_CH(8), .PWM_BITS(8), .PRESCALE(1), .STEP(100)) u_c (
    .clk(clk), .reset(reset), .pio_in(pio[2]), .fade_en(fade[2]), .led_out(led[2]), .frame_pulse(fp[2]));
  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic upd(input int k);
    int t;
    for (int c = 0; c < 8; c++) begin
      t = pio[k][c] ? 255 : 0;
      if (md[k][c] < t) md[k][c] = (md[k][c] + st[k] > 255) ? 255 : md[k][c] + st[k];
      else if (md[k][c] > t) md[k][c] = (md[k][c] < st[k]) ? 0 : md[k][c] - st[k];
    end
  endtask
  task automatic sync(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fp[k] !== 1'b1 && n < 2000);
    chk($sformatf("sync_u%0d", k), int'(fp[k] === 1'b1), 1);
    upd(k);
  endtask
  task automatic frame(input int k, input int mid, input logic [7:0] val);
    int cnt [8];
    int first, np, len, e;
    len = 256 * ps[k];
    first = -1;
    np = 0;
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (mid > 0 && i == mid / 2) pio[k] = 8'($urandom);
      if (i == mid) pio[k] = val;
      np += int'(fp[k] === 1'b1);
      if (first < 0 && led[k][0] === 1'b1) first = i;
      for (int c = 0; c < 8; c++) cnt[c] += int'(led[k][c] === 1'b1);
    end
    chk($sformatf("pulses_per_frame_u%0d", k), np, 1);
    chk($sformatf("pulse_at_frame_end_u%0d", k), int'(fp[k] === 1'b1), 1);
    for (int c = 0; c < 8; c++) begin
      e = (md[k][c] == 255 ? 256 : md[k][c]) * ps[k];
      chk($sformatf("on_time_u%0d_ch%0d", k, c), cnt[c], e);
    end
    if (md[k][0] > 0) chk($sformatf("first_high_u%0d", k), first, 1);
    upd(k);
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      pio[k] = 8'h00;
      fade[k] = 1'b1;
      for (int c = 0; c < 8; c++) md[k][c] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_led_u%0d", k), int'(led[k]), 0);
      chk($sformatf("reset_pulse_u%0d", k), int'(fp[k]), 0);
    end
    pio[0] = 8'h01;
    reset = 1'b0;
    sync(0);
    repeat (4) frame(0, 0, 8'h00);
    frame(0, 100, 8'h00);
    frame(0, 100, 8'h01);
    frame(0, 0, 8'h00);
    frame(0, 100, 8'h00);
    repeat (4) frame(0, 0, 8'h00);
    for (int i = 0; i < 8; i++) frame(0, 100, pats[i]);
    repeat (12) frame(0, int'($urandom_range(20, 230)), 8'($urandom));
    fade[0] = 1'b0;
    pio[0] = 8'h00;
    repeat (3) @(negedge clk);
    chk("snap_off", int'(led[0]), 0);
    pio[0] = 8'hA5;
    @(negedge clk);
    chk("snap_lat1", int'(led[0]), 0);
    @(negedge clk);
    chk("snap_lat2", int'(led[0]), 8'hA5);
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (led[0] !== 8'hA5) bad++;
    end
    chk("snap_hold", bad, 0);
    for (int c = 0; c < 8; c++) md[0][c] = pio[0][c] ? 255 : 0;
    fade[0] = 1'b1;
    pio[0] = 8'hFF;
    sync(0);
    frame(0, 0, 8'h00);
    repeat (50) @(negedge clk);
    chk("pre_reset_led", int'(led[0]), 8'hFF);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_led", int'(led[0]), 0);
    chk("async_reset_pulse", int'(fp[0]), 0);
    @(negedge clk);
    chk("held_reset_led", int'(led[0]), 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) md[0][c] = 0;
    sync(0);
    frame(0, 0, 8'h00);
    pio[1] = 8'h01;
    sync(1);
    frame(1, 0, 8'h00);
    frame(1, 0, 8'h00);
    pio[2] = 8'h01;
    sync(2);
    repeat (3) frame(2, 0, 8'h00);
    frame(2, 100, 8'h00);
    repeat (3) frame(2, 0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pio_led_fader.md
Name: pio_led_fader

Overview:
- Downstream consumer of the 8-bit PIO export driven by the KyogenRV Avalon-MM system.
- Turns each static PIO bit into a per-channel LED drive signal with a linear PWM fade-in/fade-out, so software on/off writes appear as smooth brightness ramps.
- Pure fabric logic on the RISC-V clock domain; sits between the Qsys PIO export and the board LED pins.

Parameters:
- N_CH, 8, number of channels (width of pio_in and led_out)
- PWM_BITS, 8, PWM counter and duty width; MAX = 2**PWM_BITS-1
- PRESCALE, 94, clk cycles per PWM tick (>=1; 1 means tick every cycle)
- STEP, 4, duty increment/decrement per PWM frame (1..MAX)

Ports:
- clk  in  1  system clock (clk_riscv domain)
- reset  in  1  asynchronous, active-high reset
- pio_in  in  N_CH  PIO export value; bit i = target state of channel i (1=on)
- fade_en  in  1  1: ramped transitions; 0: duty snaps to target
- led_out  out  N_CH  PWM drive per channel, registered
- frame_pulse  out  1  one-cycle pulse at each PWM frame boundary, registered

Behaviour:
Reset:
- On reset assertion, all state clears immediately, regardless of clock: prescaler, pwm_cnt, every duty[i], led_out=0, frame_pulse=0.
- Reset asserted mid-fade discards the ramp; after release all channels restart from duty 0.
- Outputs hold 0 while reset is high.

Prescaler:
- presc counts 0..PRESCALE-1 and wraps.
- tick is high in the cycle presc==PRESCALE-1.
- PRESCALE=1 gives tick every cycle.

PWM counter:
- pwm_cnt (PWM_BITS wide) increments on tick and wraps MAX->0.
- frame_end = tick && pwm_cnt==MAX.
- frame_pulse is registered frame_end, i.e. it rises the cycle after frame_end.

Target:
- tgt[i] = pio_in[i] ? MAX : 0.
- pio_in is sampled directly (same clock domain as the PIO); no synchronizer.

Duty update, per channel, in priority order:
1. fade_en==0: duty[i] <= tgt[i] every cycle (one-cycle snap, not frame-aligned).
2. fade_en==1 and frame_end:
   - duty<tgt: duty <= min(duty+STEP, MAX)
   - duty>tgt: duty <= (duty<STEP) ? 0 : duty-STEP
   - equal: hold
3. Otherwise: hold.
- Arithmetic uses PWM_BITS+1 bits internally; duty never wraps.
- A pio_in change mid-ramp reverses direction at the next frame_end from the current duty (no restart).
- pio_in toggling within one frame: only the value present at frame_end matters.
- fade_en 1->0 mid-ramp: duty snaps to target next cycle. fade_en 0->1: ramping resumes at the next frame_end.

Output compare (registered, one-cycle latency from duty/pwm_cnt):
- duty==0: led_out[i] <= 0
- duty==MAX: led_out[i] <= 1 (true 100%, no glitch)
- else: led_out[i] <= (pwm_cnt < duty)
- On-time per frame is exactly duty ticks for 0<duty<MAX.

Timing:
- Full ramp 0->MAX takes ceil(MAX/STEP) frames. Each frame is 2**PWM_BITS ticks = PRESCALE*2**PWM_BITS clk cycles.
- Because duty changes only at frame_end, pwm_cnt==0 always starts a frame with a stable duty; no mid-frame glitches when fade_en=1.

Test Plan (bench uses PRESCALE=1, PWM_BITS=8, STEP=64 unless stated):
- Reset check: assert reset mid-run with pio_in=8'hFF, fade_en=1, duty ~128 -> led_out=0 and frame_pulse=0 immediately (before next clk edge); after release, ch0 duty restarts from 0.
- Fade-in: pio_in=8'h01, fade_en=1 from duty 0 -> ch0 duty 64,128,192,255 at successive frame_ends (saturate, not 256). Per-frame high count 64,128,192, then constant high. Other channels stay 0.
- Fade-out with reversal: ch0 at 255, pio_in->0; after one frame_end (duty 191) set pio_in=1 -> duty 255 at the next frame_end. Then pio_in=0 and STEP=100 -> duty 155,55,0 (clamped, no underflow).
- Snap: fade_en=0, pio_in 8'h00->8'hA5 -> duty snaps next cycle; led_out==8'hA5 two cycles after the change and stays constant across frames.
- Prescale/frame timing: PRESCALE=3 -> frame_pulse period exactly 768 clk, width 1 cycle. With duty=10, led_out high for exactly 30 clk per frame, starting the cycle after pwm_cnt reaches 0.
- Independent channels: pio_in=8'h81, fade_en=1 -> ch0 and ch7 ramp identically, ch1..ch6 stay 0. At the same frame_end, ch7 going 1->0 and ch0 going 0->1 both update without interference.
